// File: rtl/rs_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_dsp_pkg
// Description : Shared widths, saturation bounds, control structs and lane
//               slicing helpers for the dual-lane 10x9 MAC model.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_dsp_pkg;

  localparam int LANE_A_W = 10;
  localparam int LANE_B_W = 9;
  localparam int LANE_Z_W = 19;
  localparam int ACC_W    = 32;
  localparam int PROD_W   = 20;
  localparam int FMT_W    = ACC_W + 1;

  // Clamp bounds compared against the widened, shifted accumulator
  localparam logic signed [FMT_W-1:0] SAT_S_MAX = 33'sd262143;
  localparam logic signed [FMT_W-1:0] SAT_S_MIN = -33'sd262144;
  localparam logic signed [FMT_W-1:0] SAT_U_MAX = 33'sd524287;
  localparam logic signed [FMT_W-1:0] SAT_U_MIN = 33'sd0;

  // Lane-sized values driven onto z when clamping
  localparam logic [LANE_Z_W-1:0] LANE_S_MAX = 19'h3FFFF;
  localparam logic [LANE_Z_W-1:0] LANE_S_MIN = 19'h40000;
  localparam logic [LANE_Z_W-1:0] LANE_U_MAX = 19'h7FFFF;
  localparam logic [LANE_Z_W-1:0] LANE_U_MIN = 19'h00000;

  // Controls that travel with the accumulator into the output formatter
  typedef struct packed {
    logic       unsigned_a;
    logic       unsigned_b;
    logic [4:0] shift_right;
    logic       round;
    logic       saturate;
  } fmt_ctl_t;

  // Full control word captured at stage 1
  typedef struct packed {
    logic [2:0] feedback;
    logic [4:0] acc_fir;
    logic       load_acc;
    logic       subtract;
    fmt_ctl_t   fmt;
  } ctl_t;

  // Lane 1 lives in the upper half of every packed word
  function automatic logic [LANE_A_W-1:0] a_lane(input logic [2*LANE_A_W-1:0] word,
                                                 input logic upper);
    return upper ? word[2*LANE_A_W-1:LANE_A_W] : word[LANE_A_W-1:0];
  endfunction

  function automatic logic [LANE_B_W-1:0] b_lane(input logic [2*LANE_B_W-1:0] word,
                                                 input logic upper);
    return upper ? word[2*LANE_B_W-1:LANE_B_W] : word[LANE_B_W-1:0];
  endfunction

  // Coefficients share the A-operand packing
  function automatic logic [LANE_A_W-1:0] coeff_unpack(input logic [2*LANE_A_W-1:0] coeff,
                                                       input logic upper);
    return a_lane(coeff, upper);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_dsp_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : rs_dsp_mac_lane
// Description : One lane: signed/unsigned 10x9 multiply, 32-bit accumulator
//               (stage 2) and combinational round/shift/saturate formatting.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_dsp_mac_lane
  import rs_dsp_pkg::*;
#(
  parameter logic ACC_MODE = 1'b1
) (
  input  logic                clk,
  input  logic                lreset,
  input  logic [LANE_A_W-1:0] a_op,
  input  logic [LANE_B_W-1:0] b_op,
  input  logic                load_acc,
  input  logic                subtract,
  input  logic [4:0]          acc_fir,
  input  fmt_ctl_t            fmt_in,
  output logic [LANE_Z_W-1:0] z_lane
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  load_term;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc;
  fmt_ctl_t                 fmt_q;
  logic signed [FMT_W-1:0]  bias;
  logic signed [FMT_W-1:0]  rounded;
  logic signed [FMT_W-1:0]  shifted;

  // Extend operands to the exact product width, then load or accumulate
  always_comb begin
    a_ext     = {{(PROD_W-LANE_A_W){~fmt_in.unsigned_a & a_op[LANE_A_W-1]}}, a_op};
    b_ext     = {{(PROD_W-LANE_B_W){~fmt_in.unsigned_b & b_op[LANE_B_W-1]}}, b_op};
    product   = a_ext * b_ext;
    prod_ext  = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    load_term = prod_ext << acc_fir;
    if (ACC_MODE && load_acc) begin
      acc_next = subtract ? (acc - prod_ext) : (acc + prod_ext);
    end else begin
      acc_next = subtract ? -load_term : load_term;
    end
  end

  // Stage 2: accumulator plus the formatting controls that belong to it
  always_ff @(posedge clk) begin
    if (lreset) begin
      acc   <= '0;
      fmt_q <= '0;
    end else begin
      acc   <= acc_next;
      fmt_q <= fmt_in;
    end
  end

  // Round half-up, arithmetic shift, then clamp or truncate to 19 bits
  always_comb begin
    bias = '0;
    if (fmt_q.round && (fmt_q.shift_right != 5'd0)) begin
      bias = FMT_W'(1) << (fmt_q.shift_right - 5'd1);
    end
    rounded = {acc[ACC_W-1], acc} + bias;
    shifted = rounded >>> fmt_q.shift_right;
    z_lane  = shifted[LANE_Z_W-1:0];
    if (fmt_q.saturate) begin
      if (fmt_q.unsigned_a && fmt_q.unsigned_b) begin
        if (shifted < SAT_U_MIN)      z_lane = LANE_U_MIN;
        else if (shifted > SAT_U_MAX) z_lane = LANE_U_MAX;
      end else begin
        if (shifted < SAT_S_MIN)      z_lane = LANE_S_MIN;
        else if (shifted > SAT_S_MAX) z_lane = LANE_S_MAX;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_dsp_mult_acc_split.sv
`default_nettype none
// ============================================================================
// Module      : rs_dsp_mult_acc_split
// Description : Dual-lane DSP slice model: stage-1 input register, operand /
//               coefficient selection, two MAC lanes, stage-3 output register.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_dsp_mult_acc_split
  import rs_dsp_pkg::*;
#(
  parameter logic [19:0] COEFF_0       = 20'h00000,
  parameter logic [19:0] COEFF_1       = 20'h00000,
  parameter logic [19:0] COEFF_2       = 20'h00000,
  parameter logic [19:0] COEFF_3       = 20'h00000,
  parameter logic        INPUT_REG_EN  = 1'b1,
  parameter logic        OUTPUT_REG_EN = 1'b1,
  parameter logic        ACC_MODE      = 1'b1
) (
  input  logic        clk,
  input  logic        lreset,
  input  logic [19:0] a,
  input  logic [17:0] b,
  input  logic [2:0]  feedback,
  input  logic [4:0]  acc_fir,
  input  logic        load_acc,
  input  logic        unsigned_a,
  input  logic        unsigned_b,
  input  logic        subtract,
  input  logic [4:0]  shift_right,
  input  logic        round,
  input  logic        saturate,
  output logic [37:0] z,
  output logic [17:0] dly_b
);

  ctl_t                in_ctl;
  ctl_t                s1_ctl;
  logic [19:0]         s1_a;
  logic [17:0]         s1_b;
  logic [17:0]         b_q;
  logic [19:0]         coeff_sel;
  logic [LANE_A_W-1:0] a_op1;
  logic [LANE_A_W-1:0] a_op2;
  logic [LANE_Z_W-1:0] z1;
  logic [LANE_Z_W-1:0] z2;

  // Gather the control inputs into one word for stage 1
  always_comb begin
    in_ctl                 = '0;
    in_ctl.feedback        = feedback;
    in_ctl.acc_fir         = acc_fir;
    in_ctl.load_acc        = load_acc;
    in_ctl.subtract        = subtract;
    in_ctl.fmt.unsigned_a  = unsigned_a;
    in_ctl.fmt.unsigned_b  = unsigned_b;
    in_ctl.fmt.shift_right = shift_right;
    in_ctl.fmt.round       = round;
    in_ctl.fmt.saturate    = saturate;
  end

  // Registered b exists in every configuration because dly_b exposes it
  always_ff @(posedge clk) begin
    if (lreset) b_q <= '0;
    else        b_q <= b;
  end
  assign dly_b = b_q;

  generate
    if (INPUT_REG_EN) begin : g_in_reg
      logic [19:0] a_q;
      ctl_t        ctl_q;
      // Stage 1: capture a and all controls
      always_ff @(posedge clk) begin
        if (lreset) begin
          a_q   <= '0;
          ctl_q <= '0;
        end else begin
          a_q   <= a;
          ctl_q <= in_ctl;
        end
      end
      assign s1_a   = a_q;
      assign s1_b   = b_q;
      assign s1_ctl = ctl_q;
    end else begin : g_in_bypass
      assign s1_a   = a;
      assign s1_b   = b;
      assign s1_ctl = in_ctl;
    end
  endgenerate

  // Pick the coefficient word and the per-lane A operand source
  always_comb begin
    case (s1_ctl.feedback[1:0])
      2'd0:    coeff_sel = COEFF_0;
      2'd1:    coeff_sel = COEFF_1;
      2'd2:    coeff_sel = COEFF_2;
      default: coeff_sel = COEFF_3;
    endcase
    a_op1 = s1_ctl.feedback[2] ? coeff_unpack(coeff_sel, 1'b1) : a_lane(s1_a, 1'b1);
    a_op2 = s1_ctl.feedback[2] ? coeff_unpack(coeff_sel, 1'b0) : a_lane(s1_a, 1'b0);
  end

  rs_dsp_mac_lane #(.ACC_MODE(ACC_MODE)) u_lane1 (
    .clk      (clk),
    .lreset   (lreset),
    .a_op     (a_op1),
    .b_op     (b_lane(s1_b, 1'b1)),
    .load_acc (s1_ctl.load_acc),
    .subtract (s1_ctl.subtract),
    .acc_fir  (s1_ctl.acc_fir),
    .fmt_in   (s1_ctl.fmt),
    .z_lane   (z1)
  );

  rs_dsp_mac_lane #(.ACC_MODE(ACC_MODE)) u_lane2 (
    .clk      (clk),
    .lreset   (lreset),
    .a_op     (a_op2),
    .b_op     (b_lane(s1_b, 1'b0)),
    .load_acc (s1_ctl.load_acc),
    .subtract (s1_ctl.subtract),
    .acc_fir  (s1_ctl.acc_fir),
    .fmt_in   (s1_ctl.fmt),
    .z_lane   (z2)
  );

  generate
    if (OUTPUT_REG_EN) begin : g_out_reg
      logic [37:0] z_q;
      // Stage 3: register the packed lane results
      always_ff @(posedge clk) begin
        if (lreset) z_q <= '0;
        else        z_q <= {z1, z2};
      end
      assign z = z_q;
    end else begin : g_out_comb
      assign z = {z1, z2};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rs_dsp_mult_acc_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_dsp_mult_acc_split
// Description : Directed + randomized bench for three configurations of the
//               dual-lane MAC (default, plain multiply, fully bypassed).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_dsp_mult_acc_split;

  localparam logic [19:0] C0 = 20'h007FF;
  localparam logic [19:0] C1 = 20'h80064;
  localparam logic [19:0] C2 = 20'h02C0D;  // {11, 13}
  localparam logic [19:0] C3 = 20'hFFDFF;

  logic        clk = 1'b0;
  logic        lreset;
  logic [19:0] a;
  logic [17:0] b;
  logic [2:0]  feedback;
  logic [4:0]  acc_fir;
  logic        load_acc, unsigned_a, unsigned_b, subtract, round, saturate;
  logic [4:0]  shift_right;
  logic [37:0] z_dut, z_mul, z_byp;
  logic [17:0] dly_dut, dly_mul, dly_byp;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: one accumulator per instance/lane, plus a result history
  logic [19:0] coeffs [4] = '{C0, C1, C2, C3};
  int          lat    [3] = '{2, 2, 0};
  bit          amode  [3] = '{1'b1, 1'b0, 1'b1};
  int          macc   [3][2];
  logic [37:0] hist   [3][3];
  logic [37:0] exp_z  [3];
  logic [17:0] exp_dly;

  always #5 clk = ~clk;

  rs_dsp_mult_acc_split #(.COEFF_0(C0), .COEFF_1(C1), .COEFF_2(C2), .COEFF_3(C3),
    .INPUT_REG_EN(1'b1), .OUTPUT_REG_EN(1'b1), .ACC_MODE(1'b1)) u_dut (
    .clk(clk), .lreset(lreset), .a(a), .b(b), .feedback(feedback), .acc_fir(acc_fir),
    .load_acc(load_acc), .unsigned_a(unsigned_a), .unsigned_b(unsigned_b),
    .subtract(subtract), .shift_right(shift_right), .round(round), .saturate(saturate),
    .z(z_dut), .dly_b(dly_dut));

  rs_dsp_mult_acc_split #(.COEFF_0(C0), .COEFF_1(C1), .COEFF_2(C2), .COEFF_3(C3),
    .INPUT_REG_EN(1'b1), .OUTPUT_REG_EN(1'b1), .ACC_MODE(1'b0)) u_mul (
    .clk(clk), .lreset(lreset), .a(a), .b(b), .feedback(feedback), .acc_fir(acc_fir),
    .load_acc(load_acc), .unsigned_a(unsigned_a), .unsigned_b(unsigned_b),
    .subtract(subtract), .shift_right(shift_right), .round(round), .saturate(saturate),
    .z(z_mul), .dly_b(dly_mul));

  rs_dsp_mult_acc_split #(.COEFF_0(C0), .COEFF_1(C1), .COEFF_2(C2), .COEFF_3(C3),
    .INPUT_REG_EN(1'b0), .OUTPUT_REG_EN(1'b0), .ACC_MODE(1'b1)) u_byp (
    .clk(clk), .lreset(lreset), .a(a), .b(b), .feedback(feedback), .acc_fir(acc_fir),
    .load_acc(load_acc), .unsigned_a(unsigned_a), .unsigned_b(unsigned_b),
    .subtract(subtract), .shift_right(shift_right), .round(round), .saturate(saturate),
    .z(z_byp), .dly_b(dly_byp));

  // New accumulator value for one lane transaction, in plain integer arithmetic
  function automatic int ref_acc(int acc, logic [9:0] av, logic [8:0] bv, logic ua,
                                 logic ub, logic sub, logic ld, bit am, logic [4:0] fir);
    longint pa, pb, p;
    int     t;
    pa = ua ? longint'(av) : longint'($signed(av));
    pb = ub ? longint'(bv) : longint'($signed(bv));
    p  = pa * pb;
    if (am && ld) return sub ? acc - int'(p) : acc + int'(p);
    t = int'(p << fir);
    return sub ? -t : t;
  endfunction

  // Output value for an accumulator under the given formatting controls
  function automatic logic [18:0] ref_fmt(int acc, logic ua, logic ub, logic [4:0] sr,
                                          logic rnd, logic sat);
    longint t;
    t = longint'(acc);
    if (rnd && sr != 5'd0) t = t + (longint'(1) << (sr - 5'd1));
    t = t >>> sr;
    if (sat) begin
      if (ua && ub) begin
        if (t < 0) t = 0;
        else if (t > 524287) t = 524287;
      end else begin
        if (t < -262144) t = -262144;
        else if (t > 262143) t = 262143;
      end
    end
    return t[18:0];
  endfunction

  // Apply the transaction present at this clock edge to every reference instance
  task automatic model_edge();
    logic [9:0]  av;
    logic [8:0]  bv;
    logic [19:0] c;
    logic [18:0] zl [2];
    for (int i = 0; i < 3; i++) begin
      if (lreset) begin
        for (int j = 0; j < 3; j++) hist[i][j] = '0;
        macc[i][0] = 0;
        macc[i][1] = 0;
        exp_z[i]   = '0;
      end else begin
        c = coeffs[feedback[1:0]];
        for (int ln = 0; ln < 2; ln++) begin
          if (feedback[2]) av = (ln == 0) ? c[19:10] : c[9:0];
          else             av = (ln == 0) ? a[19:10] : a[9:0];
          bv = (ln == 0) ? b[17:9] : b[8:0];
          macc[i][ln] = ref_acc(macc[i][ln], av, bv, unsigned_a, unsigned_b, subtract,
                                load_acc, amode[i], acc_fir);
          zl[ln] = ref_fmt(macc[i][ln], unsigned_a, unsigned_b, shift_right, round, saturate);
        end
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        hist[i][0] = {zl[0], zl[1]};
        exp_z[i]   = hist[i][lat[i]];
      end
    end
    exp_dly = lreset ? 18'd0 : b;
  endtask

  task automatic chk(string tag, logic [37:0] obs, logic [37:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_lane(string tag, logic [18:0] obs, int expv);
    logic [18:0] e;
    e = expv[18:0];
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(e));
    end
  endtask

  // One clock: update the reference at the edge, compare on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("z_default", z_dut, exp_z[0]);
    chk("z_plainmul", z_mul, exp_z[1]);
    chk("z_bypass", z_byp, exp_z[2]);
    chk("dly_b", {20'd0, dly_dut}, {20'd0, exp_dly});
    chk("dly_b_byp", {20'd0, dly_byp}, {20'd0, exp_dly});
  endtask

  task automatic set_ops(int a1, int a2, int b1, int b2);
    a = {10'(a1), 10'(a2)};
    b = {9'(b1), 9'(b2)};
  endtask

  initial begin
    lreset = 1'b1; a = '0; b = '0; feedback = '0; acc_fir = '0; load_acc = 1'b0;
    unsigned_a = 1'b0; unsigned_b = 1'b0; subtract = 1'b0; shift_right = '0;
    round = 1'b0; saturate = 1'b0;

    // Reset for two cycles, then keep it asserted under live operands
    cycle(); cycle();
    chk("reset_z", z_dut, 38'd0);
    chk("reset_dly", {20'd0, dly_dut}, 38'd0);
    for (int k = 0; k < 3; k++) begin
      set_ops($urandom, $urandom, $urandom, $urandom);
      load_acc = 1'b1;
      cycle();
      chk("reset_hold_z", z_dut, 38'd0);
    end

    // Plain multiply
    lreset = 1'b0; load_acc = 1'b0;
    set_ops(3, 5, 7, 9);
    cycle(); cycle(); cycle();
    chk_lane("mul_z1", z_mul[37:19], 21);
    chk_lane("mul_z2", z_mul[18:0], 45);

    // Signed MAC: load then accumulate
    set_ops(-2, 0, 4, 0);
    cycle();
    load_acc = 1'b1;
    cycle(); cycle();
    chk_lane("mac_1", z_dut[37:19], -8);
    cycle(); chk_lane("mac_2", z_dut[37:19], -16);
    cycle(); chk_lane("mac_3", z_dut[37:19], -24);
    cycle(); chk_lane("mac_4", z_dut[37:19], -32);

    // Coefficient select
    load_acc = 1'b0; feedback = 3'b110;
    set_ops($urandom, $urandom, 2, 2);
    cycle(); cycle(); cycle();
    chk_lane("coeff_z1", z_dut[37:19], 22);
    chk_lane("coeff_z2", z_dut[18:0], 26);

    // Round then shift
    feedback = 3'b000; shift_right = 5'd2; round = 1'b1;
    set_ops(37, 0, 1, 0);
    cycle(); cycle(); cycle();
    chk_lane("round_shift", z_dut[37:19], 9);
    shift_right = 5'd0; round = 1'b0;

    // Saturating accumulation of 511*255
    saturate = 1'b1;
    set_ops(511, 0, 255, 0);
    cycle();
    load_acc = 1'b1;
    cycle(); cycle(); cycle(); cycle();
    chk_lane("sat_pin", z_dut[37:19], 262143);

    // Same without saturation: low 19 bits of 3*130305
    saturate = 1'b0; load_acc = 1'b0;
    cycle();
    load_acc = 1'b1;
    cycle(); cycle(); cycle(); cycle();
    chk_lane("sat_off_wrap", z_dut[37:19], 390915);

    // Fully bypassed configuration, then reset during accumulation
    load_acc = 1'b0;
    set_ops(3, 5, 7, 9);
    cycle(); chk_lane("byp_load", z_byp[37:19], 21);
    load_acc = 1'b1;
    cycle(); chk_lane("byp_acc1", z_byp[37:19], 42);
    cycle(); chk_lane("byp_acc2", z_byp[37:19], 63);
    lreset = 1'b1;
    cycle();
    chk("byp_reset_z", z_byp, 38'd0);
    chk("dut_reset_z", z_dut, 38'd0);
    lreset = 1'b0;
    cycle(); chk_lane("byp_restart", z_byp[37:19], 21);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      lreset      = ($urandom_range(0, 39) == 0);
      a           = 20'($urandom);
      b           = 18'($urandom);
      feedback    = 3'($urandom);
      acc_fir     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      load_acc    = ($urandom_range(0, 3) != 0);
      unsigned_a  = 1'($urandom);
      unsigned_b  = 1'($urandom);
      subtract    = 1'($urandom);
      shift_right = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      round       = 1'($urandom);
      saturate    = 1'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
